// File: rtl/masked_io_pkg.sv
// Shared types and helpers for the masked cipher stream front-end.
// Holds the FSM encoding, default parameters and share recombination.
package masked_io_pkg;

  localparam int DEF_SHARES      = 2;
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_BLOCK_BYTES = 16;
  localparam int DEF_KEY_MASK    = 0;

  localparam int MAX_SHARES = 8;
  localparam int MAX_WIDTH  = 32;
  localparam int SX_BITS    = (MAX_SHARES + 1) * MAX_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FEED    = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } state_e;

  // Slices overlap upward, so only the low `width` bits are meaningful.
  function automatic logic [MAX_WIDTH-1:0] share_xor(
    input logic [SX_BITS-1:0] v,
    input int                 shares,
    input int                 width
  );
    logic [MAX_WIDTH-1:0] acc;
    acc = '0;
    for (int i = 0; i < MAX_SHARES; i++) begin
      if (i < shares)
        acc = acc ^ v[i*width +: MAX_WIDTH];
    end
    return acc & ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
  endfunction

endpackage

// File: rtl/masked_stream_adapter_share_split.sv
// Boolean share generation: share 0 carries data ^ all masks,
// shares 1..S-1 are the raw mask slices.
module share_split #(
  parameter int SHARES = 2,
  parameter int WIDTH  = 8
) (
  input  logic [WIDTH-1:0]            data,
  input  logic [(SHARES-1)*WIDTH-1:0] rnd,
  output logic [SHARES*WIDTH-1:0]     shares
);

  logic [WIDTH-1:0] masked;

  always_comb begin
    masked = data;
    for (int i = 0; i < SHARES-1; i++)
      masked = masked ^ rnd[i*WIDTH +: WIDTH];
  end

  assign shares = {rnd, masked};

endmodule

// File: rtl/masked_stream_adapter.sv
// Block-buffering share front-end for byte-serial masked cipher cores:
// load a block, feed shares without stalls, capture and drain the result.
module masked_stream_adapter
  import masked_io_pkg::*;
#(
  parameter int SHARES      = DEF_SHARES,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int BLOCK_BYTES = DEF_BLOCK_BYTES,
  parameter int KEY_MASK    = DEF_KEY_MASK
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_pt,
  input  logic [WIDTH-1:0]            in_key,
  input  logic [(SHARES-1)*WIDTH-1:0] rnd,
  output logic                        cipher_rst,
  output logic [SHARES*WIDTH-1:0]     cipher_in,
  output logic [SHARES*WIDTH-1:0]     cipher_key,
  input  logic [SHARES*WIDTH-1:0]     cipher_out,
  input  logic                        cipher_done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_ct,
  output logic                        out_last,
  output logic                        busy
);

  localparam int IW  = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int SW  = SHARES * WIDTH;
  localparam int PAD = SX_BITS - SW;

  localparam logic [IW-1:0] LAST = IW'(BLOCK_BYTES - 1);
  localparam logic [IW-1:0] ONE  = IW'(1);

  localparam logic [2:0] S_IDLE    = IDLE;
  localparam logic [2:0] S_FEED    = FEED;
  localparam logic [2:0] S_WAIT    = WAIT;
  localparam logic [2:0] S_CAPTURE = CAPTURE;
  localparam logic [2:0] S_DRAIN   = DRAIN;

  logic [2:0]    state;
  logic [IW-1:0] idx;

  logic [WIDTH-1:0] pt_buf  [BLOCK_BYTES];
  logic [WIDTH-1:0] key_buf [BLOCK_BYTES];
  logic [WIDTH-1:0] obuf    [BLOCK_BYTES];

  logic [SW-1:0]               pt_sh;
  logic [SW-1:0]               key_sh;
  logic [(SHARES-1)*WIDTH-1:0] key_rnd;
  logic [WIDTH-1:0]            out_x;
  logic                        in_fire;
  logic                        out_fire;
  logic                        idx_last;
  logic                        cap_en;

  // Unmasked key: zero masks leave share 0 = key, others = 0.
  assign key_rnd = (KEY_MASK != 0) ? rnd : '0;

  share_split #(
    .SHARES (SHARES),
    .WIDTH  (WIDTH)
  ) u_pt_split (
    .data   (pt_buf[idx]),
    .rnd    (rnd),
    .shares (pt_sh)
  );

  share_split #(
    .SHARES (SHARES),
    .WIDTH  (WIDTH)
  ) u_key_split (
    .data   (key_buf[idx]),
    .rnd    (key_rnd),
    .shares (key_sh)
  );

  assign out_x = WIDTH'(share_xor({{PAD{1'b0}}, cipher_out},
                                  SHARES, WIDTH));

  assign in_ready  = (state == S_IDLE);
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (state == S_DRAIN);
  assign out_fire  = out_valid && out_ready;
  assign idx_last  = (idx == LAST);
  assign out_ct    = out_valid ? obuf[idx] : '0;
  assign out_last  = out_valid && idx_last;
  assign busy      = (state != S_IDLE);
  assign cap_en    = ((state == S_WAIT) && cipher_done)
                  || (state == S_CAPTURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_fire) begin
            idx <= idx_last ? '0 : idx + ONE;
            if (idx_last)
              state <= S_FEED;
          end
        end
        S_FEED: begin
          idx <= idx_last ? '0 : idx + ONE;
          if (idx_last)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (cipher_done) begin
            idx   <= ONE;
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          idx <= idx_last ? '0 : idx + ONE;
          if (idx_last)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_fire) begin
            idx <= idx_last ? '0 : idx + ONE;
            if (idx_last)
              state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Share registers lag the FEED index by one edge; start tracks beat 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cipher_in  <= '0;
      cipher_key <= '0;
      cipher_rst <= 1'b1;
    end else if (state == S_FEED) begin
      cipher_in  <= pt_sh;
      cipher_key <= key_sh;
      cipher_rst <= (idx == '0);
    end else begin
      cipher_in  <= '0;
      cipher_key <= '0;
      cipher_rst <= (state == S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      pt_buf[idx]  <= in_pt;
      key_buf[idx] <= in_key;
    end
    if (cap_en)
      obuf[idx] <= out_x;
  end

endmodule

// File: tb/tb_masked_stream_adapter.sv
// Randomized bench: two adapters (3-share masked key, 2-share raw key)
// driven in lockstep, each with a stub core built from observed shares.
module tb_masked_stream_adapter;

  localparam int W  = 8;
  localparam int BB = 16;
  localparam int SA = 3;
  localparam int SB = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          in_valid    = 1'b0;
  logic [W-1:0]  in_pt       = '0;
  logic [W-1:0]  in_key      = '0;
  logic [15:0]   rnd         = '0;
  logic [15:0]   rnd_s       = '0;
  logic          cipher_done = 1'b0;
  logic          out_ready   = 1'b0;

  logic [SA*W-1:0] ci_a, ck_a;
  logic [SA*W-1:0] co_a = '0;
  logic [SB*W-1:0] ci_b, ck_b;
  logic [SB*W-1:0] co_b = '0;

  logic         in_ready_a, crst_a, out_valid_a, out_last_a, busy_a;
  logic         in_ready_b, crst_b, out_valid_b, out_last_b, busy_b;
  logic [W-1:0] out_ct_a, out_ct_b;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] pt   [BB];
  logic [W-1:0] key  [BB];
  logic [W-1:0] ct   [BB];
  logic [W-1:0] npt  [BB];
  logic [W-1:0] nkey [BB];
  logic [W-1:0] opa  [BB];
  logic [W-1:0] oka  [BB];
  logic [W-1:0] opb  [BB];
  logic [W-1:0] okb  [BB];

  always #5 clk = ~clk;

  masked_stream_adapter #(
    .SHARES(SA), .WIDTH(W), .BLOCK_BYTES(BB), .KEY_MASK(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_a),
    .in_pt(in_pt), .in_key(in_key), .rnd(rnd),
    .cipher_rst(crst_a), .cipher_in(ci_a), .cipher_key(ck_a),
    .cipher_out(co_a), .cipher_done(cipher_done),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_ct(out_ct_a), .out_last(out_last_a), .busy(busy_a)
  );

  masked_stream_adapter #(
    .SHARES(SB), .WIDTH(W), .BLOCK_BYTES(BB), .KEY_MASK(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pt(in_pt), .in_key(in_key), .rnd(rnd[W-1:0]),
    .cipher_rst(crst_b), .cipher_in(ci_b), .cipher_key(ck_b),
    .cipher_out(co_b), .cipher_done(cipher_done),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_ct(out_ct_b), .out_last(out_last_b), .busy(busy_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] x3(input logic [SA*W-1:0] v);
    return v[7:0] ^ v[15:8] ^ v[23:16];
  endfunction

  function automatic logic [W-1:0] x2(input logic [SB*W-1:0] v);
    return v[7:0] ^ v[15:8];
  endfunction

  // Stand-in cipher: any bijective byte map exercises the datapath.
  function automatic logic [W-1:0] stub_f(input logic [W-1:0] p,
                                          input logic [W-1:0] k);
    return {p[3:0], p[7:4]} ^ k ^ 8'h63;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    rnd_s = rnd;
    rnd   = 16'($urandom);
  endtask

  task automatic gen_next();
    for (int i = 0; i < BB; i++) begin
      npt[i]  = 8'($urandom);
      nkey[i] = 8'($urandom);
    end
  endtask

  task automatic drive_core(input logic [W-1:0] va,
                            input logic [W-1:0] vb);
    logic [15:0] r;
    r    = 16'($urandom);
    co_a = {r[15:8], r[7:0], va ^ r[7:0] ^ r[15:8]};
    co_b = {r[15:8], vb ^ r[15:8]};
  endtask

  task automatic reset_checks(input string ph);
    check({ph, "_in_ready"}, 32'(in_ready_a), 32'd1);
    check({ph, "_cipher_rst"}, 32'(crst_a), 32'd1);
    check({ph, "_cipher_in"}, 32'(ci_a), 32'd0);
    check({ph, "_cipher_key"}, 32'(ck_a), 32'd0);
    check({ph, "_out_ct"}, 32'(out_ct_a), 32'd0);
    check({ph, "_out_valid"}, 32'(out_valid_a), 32'd0);
    check({ph, "_out_last"}, 32'(out_last_a), 32'd0);
    check({ph, "_busy"}, 32'(busy_a), 32'd0);
    check({ph, "_b_cipher_rst"}, 32'(crst_b), 32'd1);
  endtask

  task automatic run_block(input bit bp, input bit spur,
                           input bit hold, input bit hold_prev,
                           input bit abort);
    bit          hs;
    int          tries;
    int          got;
    int          c;
    int          lat;
    logic [3:0]  pat;
    pat = 4'b1001;
    for (int i = 0; i < BB; i++) begin
      pt[i]  = npt[i];
      key[i] = nkey[i];
      ct[i]  = stub_f(npt[i], nkey[i]);
    end
    gen_next();

    for (int i = 0; i < BB; i++) begin
      in_valid = 1'b1;
      in_pt    = pt[i];
      in_key   = key[i];
      tries    = 0;
      hs       = 1'b0;
      while (!hs && tries < 50) begin
        hs = in_ready_a;
        step();
        tries++;
      end
      if (!hs)
        check("send_timeout", 32'd0, 32'd1);
      if (i == 0 && hold_prev)
        check("next_block_latency", 32'(tries), 32'd1);
    end

    check("load_busy", 32'(busy_a), 32'd1);
    check("load_in_ready", 32'(in_ready_a), 32'd0);
    check("load_cipher_rst", 32'(crst_a), 32'd1);

    for (int k = 0; k < BB; k++) begin
      in_valid    = 1'b1;
      in_pt       = 8'($urandom);
      in_key      = 8'($urandom);
      cipher_done = spur && (k == 5);
      step();
      opa[k] = x3(ci_a);
      oka[k] = x3(ck_a);
      opb[k] = x2(ci_b);
      okb[k] = x2(ck_b);
      check("feed_pt_a", 32'(opa[k]), 32'(pt[k]));
      check("feed_key_a", 32'(oka[k]), 32'(key[k]));
      check("feed_sh1_a", 32'(ci_a[15:8]), 32'(rnd_s[7:0]));
      check("feed_sh2_a", 32'(ci_a[23:16]), 32'(rnd_s[15:8]));
      check("feed_rst_a", 32'(crst_a), 32'(k == 0));
      check("feed_pt_b", 32'(opb[k]), 32'(pt[k]));
      check("feed_sh1_b", 32'(ci_b[15:8]), 32'(rnd_s[7:0]));
      check("feed_key0_b", 32'(ck_b[7:0]), 32'(key[k]));
      check("feed_key1_b", 32'(ck_b[15:8]), 32'd0);
      check("feed_in_ready", 32'(in_ready_a), 32'd0);
      if (abort && k == 6) begin
        #2;
        rst = 1'b1;
        #1;
        reset_checks("midfeed");
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        reset_checks("post_abort");
        return;
      end
    end
    in_valid    = 1'b0;
    cipher_done = 1'b0;

    lat = $urandom_range(1, 4);
    for (int i = 0; i < lat; i++)
      step();
    check("wait_cipher_in", 32'(ci_a), 32'd0);
    check("wait_cipher_key", 32'(ck_a), 32'd0);
    check("wait_cipher_rst", 32'(crst_a), 32'd0);
    check("wait_out_valid", 32'(out_valid_a), 32'd0);
    check("wait_busy", 32'(busy_a), 32'd1);

    cipher_done = 1'b1;
    drive_core(stub_f(opa[0], oka[0]), stub_f(opb[0], okb[0]));
    step();
    for (int j = 1; j < BB; j++) begin
      cipher_done = 1'($urandom);
      drive_core(stub_f(opa[j], oka[j]), stub_f(opb[j], okb[j]));
      step();
    end
    cipher_done = 1'b0;

    got = 0;
    c   = 0;
    while (got < BB && c < 200) begin
      out_ready = bp ? pat[c % 4] : 1'b1;
      in_valid  = hold;
      in_pt     = npt[0];
      in_key    = nkey[0];
      check("drain_valid", 32'(out_valid_a), 32'd1);
      check("drain_ct_a", 32'(out_ct_a), 32'(ct[got]));
      check("drain_ct_b", 32'(out_ct_b), 32'(ct[got]));
      check("drain_last", 32'(out_last_a), 32'(got == BB-1));
      check("drain_in_ready", 32'(in_ready_a), 32'd0);
      if (out_ready)
        got++;
      step();
      c++;
    end
    if (got < BB)
      check("drain_timeout", 32'(got), 32'(BB));
    out_ready = 1'b0;
    if (!hold)
      in_valid = 1'b0;
    check("done_busy", 32'(busy_a), 32'd0);
    check("done_in_ready", 32'(in_ready_a), 32'd1);
    check("done_out_valid", 32'(out_valid_a), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [127:0] fp;
    logic [127:0] fk;
    fp = 128'h3243f6a8885a308d313198a2e0370734;
    fk = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    for (int i = 0; i < BB; i++) begin
      npt[i]  = fp[127-8*i -: 8];
      nkey[i] = fk[127-8*i -: 8];
    end

    step();
    step();
    reset_checks("reset");
    rst = 1'b0;
    step();
    reset_checks("idle");

    run_block(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_block(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run_block(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_block(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_block(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 4; b++)
      run_block(1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
